// File: rtl/mbrtu_rx_framer.sv
// mbrtu_rx_framer: Modbus RTU receive framer with T3.5 frame delimiting, byte buffer and CRC-16 check.
// Define MBRTU_T15_CHECK_EN to reject frames containing an inter-character gap of T1.5 or more.
module mbrtu_rx_framer #(
  parameter int ADDR_W    = 8,
  parameter int BUF_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inRxEnable,
  input  logic              inRxValid,
  input  logic [7:0]        inRxByte,
  input  logic              inRxErr,
  input  logic [23:0]       inT35Ticks,
  input  logic [23:0]       inT15Ticks,
  input  logic [ADDR_W-1:0] inRdAddr,
  output logic [7:0]        outRdData,
  output logic              outFrameValid,
  output logic [ADDR_W:0]   outFrameLen,
  input  logic              inFrameAck,
  output logic              outCrcErr,
  output logic              outOverrun,
  output logic              outBusy
);
  typedef enum logic [2:0] {INIT, IDLE, RCV, CHECK, READY} state_t;
  localparam logic [ADDR_W:0] DEPTH = BUF_DEPTH[ADDR_W:0];
  state_t state, state_n;
  logic [7:0] mem [BUF_DEPTH];
  logic [23:0] cnt, t35;
  logic [15:0] crc;
  logic [ADDR_W:0] len;
  logic [ADDR_W-1:0] waddr;
  logic err, timeout, room, good, gap_err, wr;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign t35     = (inT35Ticks == 24'd0) ? 24'd1 : inT35Ticks;
  // A byte in the same cycle as the timeout wins
  assign timeout = !inRxValid && (cnt == t35);
  assign room    = len < DEPTH;
  assign good    = (len >= (ADDR_W+1)'(4)) && (crc == 16'h0000) && !err;
  assign wr      = inRxEnable && inRxValid && (state == IDLE || (state == RCV && room));
  assign waddr   = (state == IDLE) ? '0 : len[ADDR_W-1:0];
  assign outBusy = (state == RCV) || (state == CHECK);
`ifdef MBRTU_T15_CHECK_EN
  assign gap_err = cnt >= ((inT15Ticks == 24'd0) ? 24'd1 : inT15Ticks);
`else
  logic unused_t15;
  assign unused_t15 = ^inT15Ticks;
  assign gap_err    = 1'b0;
`endif

  always_ff @(posedge clk)
    if (wr) mem[waddr] <= inRxByte;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) outRdData <= '0;
    else outRdData <= mem[inRdAddr];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_n;

  always_comb begin
    state_n = state;
    if (!inRxEnable) state_n = INIT;
    else case (state)
      INIT:    state_n = timeout ? IDLE : INIT;
      IDLE:    state_n = inRxValid ? RCV : IDLE;
      RCV:     state_n = timeout ? CHECK : RCV;
      CHECK:   state_n = good ? READY : IDLE;
      READY:   state_n = inFrameAck ? INIT : READY;
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt           <= '0;
      crc           <= 16'hFFFF;
      len           <= '0;
      err           <= 1'b0;
      outFrameValid <= 1'b0;
      outFrameLen   <= '0;
      outCrcErr     <= 1'b0;
      outOverrun    <= 1'b0;
    end else begin
      cnt       <= inRxValid ? '0 : (&cnt ? cnt : cnt + 1'b1);
      outCrcErr <= 1'b0;
      if (!inRxEnable) begin
        outFrameValid <= 1'b0;
        len           <= '0;
        crc           <= 16'hFFFF;
        err           <= 1'b0;
      end else case (state)
        IDLE: if (inRxValid) begin
          len <= (ADDR_W+1)'(1);
          crc <= crc_upd(16'hFFFF, inRxByte);
          err <= inRxErr;
        end
        RCV: if (inRxValid) begin
          if (room) begin
            len <= len + 1'b1;
            crc <= crc_upd(crc, inRxByte);
          end else outOverrun <= 1'b1;
          err <= err | inRxErr | !room | gap_err;
        end
        CHECK: if (good) begin
          outFrameValid <= 1'b1;
          outFrameLen   <= len;
        end else outCrcErr <= 1'b1;
        READY: if (inFrameAck) begin
          outFrameValid <= 1'b0;
          outOverrun    <= 1'b0;
        end else if (inRxValid) outOverrun <= 1'b1;
        default: ;
      endcase
    end
endmodule
